// File: rtl/riscv_v_inst_queue.sv
// Vector instruction issue queue: DEPTH-entry FIFO of {instruction, rs1 value} feeding vector
// decode, with a configuration barrier. Optional zero-latency bypass: RISCV_V_INST_QUEUE_BYPASS_EN.
module riscv_v_inst_queue #(
  parameter int DEPTH          = 4,
  parameter int BARRIER_CYCLES = 2,
  parameter int DATA_W         = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_pipe,
  input  logic                   stall,
  input  logic                   in_valid,
  input  logic [31:0]            in_instruction,
  input  logic [DATA_W-1:0]      in_rs1_data,
  output logic                   in_ready,
  output logic [31:0]            instruction_id,
  output logic [DATA_W-1:0]      int_rf_rd_data_id,
  output logic                   valid_id,
  output logic [$clog2(DEPTH):0] count,
  output logic                   barrier_active
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (BARRIER_CYCLES < 2) ? 1 : $clog2(BARRIER_CYCLES + 1);

  localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
  localparam logic [BW-1:0] BARRIER_LOAD = BW'(BARRIER_CYCLES);
  localparam logic [BW-1:0] BARRIER_LAST = BW'(1);
  localparam logic [31:0]   NOP_INSTR    = 32'h0000_0013;
  localparam logic [6:0]    OPCODE_OP_V  = 7'b1010111;
  localparam logic [2:0]    FUNCT3_CFG   = 3'b111;

  typedef enum logic {
    ST_ISSUE   = 1'b0,
    ST_BARRIER = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]     bar_cnt_q, bar_cnt_d;

  logic [31:0]       instr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q  [DEPTH];

  logic [31:0]       head_instr;
  logic [DATA_W-1:0] head_data;
  logic [31:0]       issue_instr;
  logic [DATA_W-1:0] issue_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_valid;
  logic              bypass_sel;
  logic              pop_fifo;
  logic              take_bypass;
  logic              issue_fire;
  logic              push;
  logic              issue_is_cfg;

  assign head_instr = instr_mem_q[rd_ptr_q];
  assign head_data  = data_mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign in_ready   = !fifo_full && !clear_pipe && !rst;
  assign fifo_valid = (state_q == ST_ISSUE) && !fifo_empty;

`ifdef RISCV_V_INST_QUEUE_BYPASS_EN
  // An empty, unblocked queue forwards the incoming instruction straight to decode.
  assign bypass_sel  = (state_q == ST_ISSUE) && fifo_empty && in_valid && in_ready;
  assign issue_instr = bypass_sel ? in_instruction : head_instr;
  assign issue_data  = bypass_sel ? in_rs1_data : head_data;
`else
  assign bypass_sel  = 1'b0;
  assign issue_instr = head_instr;
  assign issue_data  = head_data;
`endif

  assign valid_id          = fifo_valid || bypass_sel;
  assign instruction_id    = valid_id ? issue_instr : NOP_INSTR;
  assign int_rf_rd_data_id = valid_id ? issue_data : '0;
  assign barrier_active    = (state_q == ST_BARRIER);
  assign count             = count_q;

  assign pop_fifo     = fifo_valid && !stall;
  assign take_bypass  = bypass_sel && !stall;
  assign issue_fire   = pop_fifo || take_bypass;
  assign push         = in_valid && in_ready && !take_bypass;
  assign issue_is_cfg = (issue_instr[6:0] == OPCODE_OP_V) && (issue_instr[14:12] == FUNCT3_CFG);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    bar_cnt_d = bar_cnt_q;
    if (clear_pipe) begin
      state_d   = ST_ISSUE;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      bar_cnt_d = '0;
    end else begin
      // Pointers are PW bits wide, so wrap modulo DEPTH comes for free.
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop_fifo);
      case ({push, pop_fifo})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      case (state_q)
        ST_ISSUE: begin
          if (issue_fire && issue_is_cfg && (BARRIER_CYCLES > 0)) begin
            state_d   = ST_BARRIER;
            bar_cnt_d = BARRIER_LOAD;
          end
        end
        ST_BARRIER: begin
          // Only cycles in which decode advances count towards the barrier.
          if (!stall) begin
            bar_cnt_d = bar_cnt_q - BW'(1);
            if (bar_cnt_q == BARRIER_LAST) begin
              state_d = ST_ISSUE;
            end
          end
        end
        default: state_d = ST_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ISSUE;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      bar_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      bar_cnt_q <= bar_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= in_instruction;
      data_mem_q[wr_ptr_q]  <= in_rs1_data;
    end
  end

endmodule

// File: doc/riscv_v_inst_queue.md
# riscv_v_inst_queue

Vector instruction issue queue between the scalar integer pipeline and the vector decode stage. It buffers OP-V instructions with their scalar operand (rs1 value) in a DEPTH-entry FIFO and presents them to vector decode as `instruction_id` / `int_rf_rd_data_id`. It serialises vector configuration instructions (vsetvli/vsetivli/vsetvl) by holding issue for a fixed number of advancing cycles, so the next instruction sees the updated vtype/vl CSRs. It honours the decode stall and the pipeline clear.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- BARRIER_CYCLES, 2: advancing cycles issue is held after a configuration instruction; 0 disables the barrier.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- clear_pipe  input  1  synchronous flush of queue and barrier.
- stall  input  1  vector decode cannot accept; head is held.
- in_valid  input  1  scalar pipeline presents an OP-V instruction.
- in_instruction  input  32 (riscv_instruction_t)  instruction word.
- in_rs1_data  input  XLEN (riscv_data_t)  scalar rs1 operand.
- in_ready  output  1  queue accepts this cycle.
- instruction_id  output  32  instruction to vector decode.
- int_rf_rd_data_id  output  XLEN  scalar operand to vector decode.
- valid_id  output  1  instruction_id is a real instruction.
- count  output  $clog2(DEPTH)+1  current occupancy.
- barrier_active  output  1  configuration barrier in progress.

## Operation
- Push: in_valid && in_ready writes {in_instruction, in_rs1_data} at the tail.
- Pop: valid_id && !stall removes the head.
- in_ready = (count < DEPTH) && !clear_pipe && !rst. No same-cycle credit from a pop when full.
- Push and pop in one cycle: count unchanged; pointers both advance, wrapping modulo DEPTH.
- Bubble: when valid_id = 0, instruction_id = 32'h0000_0013 (non-OP-V, decode treats as no-op), int_rf_rd_data_id = 0.
- Configuration instruction: opcode[6:0] = 7'b1010111 and funct3[14:12] = 3'b111.
- FSM states:
  - ISSUE: valid_id = (count != 0). A config instruction popped with BARRIER_CYCLES > 0 loads barrier_cnt = BARRIER_CYCLES and moves to BARRIER.
  - BARRIER: valid_id = 0, barrier_active = 1. barrier_cnt decrements on each cycle with stall = 0. When barrier_cnt is 1 and stall = 0, move to ISSUE next cycle. Pushes still accepted.
- clear_pipe: count, pointers and barrier_cnt go to 0 and FSM goes to ISSUE next cycle. Input in that cycle is dropped; any pop in that cycle is discarded. Same effect as rst.
- Reset values: count = 0, valid_id = 0, in_ready = 0 during rst (1 after), instruction_id = 32'h0000_0013, int_rf_rd_data_id = 0, barrier_active = 0, FSM = ISSUE.
- Storage contents are not reset.

## Timing
- Push at cycle N: entry visible on the outputs at cycle N+1 at the earliest (non-bypass).
- Throughput: one pop per cycle when not stalled and not in BARRIER.
- Outputs are driven combinationally from head storage and FSM registers. No combinational path from in_* to outputs, except under the bypass macro.
- stall held: head, valid_id and barrier_cnt are frozen.
- Config instruction popped at cycle N with no stalls: valid_id = 0 for cycles N+1 … N+BARRIER_CYCLES; the next instruction issues at N+BARRIER_CYCLES+1.

## Configuration
- RISCV_V_INST_QUEUE_BYPASS_EN defined: when count = 0, FSM = ISSUE and in_valid = 1, the input drives instruction_id / int_rf_rd_data_id with valid_id = 1 in the same cycle (zero latency).
  - If stall = 0, the instruction is consumed and not written.
  - If stall = 1, it is written to the FIFO as a normal push.
- Undefined: minimum latency is 1 cycle, with no in_* → *_id path.

## Test plan
- Reset then idle: valid_id = 0, instruction_id = 32'h0000_0013, count = 0, in_ready = 1 after rst deasserts.
- Push 4 instructions back-to-back with stall = 1: count = 4, in_ready = 0, 5th push ignored. Release stall: 4 instructions issue in order on 4 consecutive cycles, count returns to 0.
- Simultaneous push/pop at count = 2 for 10 cycles: count stays 2, order preserved across pointer wrap.
- Push vsetvli (0x0C0572D7) followed by vadd.vv: vadd withheld for exactly 2 cycles with barrier_active = 1. Insert 3 stall cycles during the barrier: hold extends to 5 cycles.
- clear_pipe asserted with count = 3 mid-barrier: next cycle count = 0, barrier_active = 0, valid_id = 0; same-cycle input not stored.
- Bypass macro: single push into empty queue with stall = 0 gives valid_id = 1 the same cycle and count stays 0. Without the macro: valid_id = 1 the next cycle.
